// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch front end.
//   OP_*             primary opcodes (instr[31:26]) that fetch must recognise
//   DEFAULT_RESET_PC default first fetch address
//   fetch_state_e    fetch FSM state encoding
//   word_align()     clears the byte-offset bits of an address
package cpu_pkg;

    localparam logic [5:0]  OP_HALT = 6'h3f;
    localparam logic [5:0]  OP_J    = 6'h02;
    localparam logic [5:0]  OP_BEQ  = 6'h04;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ    = 2'd0,
        FETCH_VALID  = 2'd1,
        FETCH_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection for a consumed instruction.
//   pc            in  32  address of the consumed instruction
//   jump          in  1   consumed instruction is a jump
//   jump_target   in  26  jump target field
//   branch_taken  in  1   consumed beq resolved taken
//   branch_offset in  16  beq word offset
//   pc_plus4      out 32  pc + 4 (wraps modulo 2^32)
//   next_pc       out 32  word-aligned address to fetch next
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] branch_disp;
    logic [31:0] target;

    always_comb begin
        pc_plus4    = pc + 32'd4;
        branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};
        // Jump wins over a simultaneously taken branch.
        if (jump) begin
            target = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            target = pc_plus4 + branch_disp;
        end else begin
            target = pc_plus4;
        end
        next_pc = word_align(target);
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding-request instruction fetch with a one-entry
// instruction register, redirect on jump/branch and a sticky halt.
//   clk, reset    sole clock; synchronous active-high reset
//   imem_req/addr request and word address towards instruction memory
//   imem_ready    imem_rdata valid for the outstanding request
//   stall         consumer not accepting the presented instruction
//   jump/branch   redirect information for the instruction being consumed
//   instr, instr_valid, pc_out, pc_plus4  presented instruction and its PC
//   halted        halt instruction consumed; only reset restarts fetch
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        halted
);

    localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  next_pc;

    next_pc_calc u_next_pc_calc (
        .pc            (pc_out_q),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH_REQ;
            pc_q     <= RESET_PC_ALIGNED;
            instr_q  <= '0;
            pc_out_q <= RESET_PC_ALIGNED;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        case (state_q)
            FETCH_REQ: begin
                if (imem_ready) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = FETCH_VALID;
                end
            end
            FETCH_VALID: begin
                if (!stall) begin
                    // Halt overrides any redirect presented with it.
                    if (instr_q[31:26] == OP_HALT) begin
                        state_d = FETCH_HALTED;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH_REQ;
                    end
                end
            end
            FETCH_HALTED: begin
                state_d = FETCH_HALTED;
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase
    end

    always_comb begin
        imem_req    = (state_q == FETCH_REQ);
        imem_addr   = pc_q;
        instr       = instr_q;
        instr_valid = (state_q == FETCH_VALID);
        pc_out      = pc_out_q;
        halted      = (state_q == FETCH_HALTED);
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        jump;
    logic [25:0] jump_target;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        halted;

    // Second instance for the top-of-address-space wrap case.
    logic        reset_b;
    logic        imem_req_b;
    logic [31:0] imem_addr_b;
    logic        imem_ready_b;
    logic [31:0] imem_rdata_b;
    logic [31:0] instr_b;
    logic        instr_valid_b;
    logic [31:0] pc_out_b;
    logic [31:0] pc_plus4_b;
    logic        halted_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .halted        (halted)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
        .clk           (clk),
        .reset         (reset_b),
        .imem_req      (imem_req_b),
        .imem_addr     (imem_addr_b),
        .imem_ready    (imem_ready_b),
        .imem_rdata    (imem_rdata_b),
        .stall         (1'b0),
        .jump          (1'b0),
        .jump_target   (26'd0),
        .branch_taken  (1'b0),
        .branch_offset (16'd0),
        .instr         (instr_b),
        .instr_valid   (instr_valid_b),
        .pc_out        (pc_out_b),
        .pc_plus4      (pc_plus4_b),
        .halted        (halted_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        imem_ready    = 1'b1;
        imem_rdata    = 32'h1234_5678;
        stall         = 1'b0;
        jump          = 1'b0;
        jump_target   = '0;
        branch_taken  = 1'b0;
        branch_offset = '0;
        reset_b       = 1'b1;
        imem_ready_b  = 1'b0;
        imem_rdata_b  = '0;

        // Reset with imem_ready high: returned data must be discarded.
        tick();
        tick();
        check_eq("rst_instr",    instr, 32'h0);
        check_eq("rst_valid",    {31'd0, instr_valid}, 32'd0);
        check_eq("rst_req",      {31'd0, imem_req}, 32'd1);
        check_eq("rst_addr",     imem_addr, 32'h0);
        check_eq("rst_pc_out",   pc_out, 32'h0);
        check_eq("rst_halted",   {31'd0, halted}, 32'd0);

        // First fetch: 1-cycle ready, valid next cycle.
        reset      = 1'b0;
        imem_rdata = 32'h2002_0001;
        tick();
        check_eq("f0_valid",    {31'd0, instr_valid}, 32'd1);
        check_eq("f0_instr",    instr, 32'h2002_0001);
        check_eq("f0_pc_out",   pc_out, 32'h0);
        check_eq("f0_pc_plus4", pc_plus4, 32'h4);
        check_eq("f0_req",      {31'd0, imem_req}, 32'd0);
        imem_ready = 1'b0;
        tick();
        check_eq("f1_req",   {31'd0, imem_req}, 32'd1);
        check_eq("f1_addr",  imem_addr, 32'h4);
        check_eq("f1_valid", {31'd0, instr_valid}, 32'd0);

        // Jump from 0x4 to 0x40.
        imem_ready = 1'b1;
        imem_rdata = 32'h0800_0010;
        tick();
        imem_ready  = 1'b0;
        jump        = 1'b1;
        jump_target = 26'h10;
        tick();
        jump = 1'b0;
        check_eq("j_addr", imem_addr, 32'h40);

        // Stall for 3 cycles with branch and stray ready: all ignored.
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0AAA;
        tick();
        check_eq("s_pc_out", pc_out, 32'h40);
        imem_rdata    = 32'hDEAD_BEEF;
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_offset = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("s_instr",  instr, 32'h0000_0AAA);
            check_eq("s_pc_out", pc_out, 32'h40);
            check_eq("s_valid",  {31'd0, instr_valid}, 32'd1);
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        tick();
        check_eq("s_rel_req",  {31'd0, imem_req}, 32'd1);
        check_eq("s_rel_addr", imem_addr, 32'h44);

        // Jump from 0x44 to 0x100.
        imem_ready = 1'b1;
        imem_rdata = 32'h0800_0040;
        tick();
        imem_ready  = 1'b0;
        jump        = 1'b1;
        jump_target = 26'h40;
        tick();
        jump = 1'b0;
        check_eq("j2_addr", imem_addr, 32'h100);

        // Backward branch at 0x100: 0x104 + (-2 << 2) = 0xFC.
        imem_ready = 1'b1;
        imem_rdata = 32'h1000_FFFE;
        tick();
        imem_ready = 1'b0;
        check_eq("b_pc_out", pc_out, 32'h100);
        branch_taken  = 1'b1;
        branch_offset = 16'hFFFE;
        tick();
        branch_taken = 1'b0;
        check_eq("b_addr", imem_addr, 32'hFC);

        // Back to 0x100, then jump + branch together: jump wins.
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        jump        = 1'b1;
        jump_target = 26'h40;
        tick();
        check_eq("j3_addr", imem_addr, 32'h100);
        imem_ready = 1'b1;
        jump       = 1'b0;
        tick();
        imem_ready    = 1'b0;
        jump          = 1'b1;
        jump_target   = 26'h10;
        branch_taken  = 1'b1;
        branch_offset = 16'hFFFE;
        tick();
        jump         = 1'b0;
        branch_taken = 1'b0;
        check_eq("jb_addr", imem_addr, 32'h40);

        // Halt overrides a redirect and sticks until reset.
        imem_ready = 1'b1;
        imem_rdata = 32'hFC00_0000;
        tick();
        imem_ready  = 1'b0;
        jump        = 1'b1;
        jump_target = 26'h123;
        tick();
        jump = 1'b0;
        check_eq("h_halted", {31'd0, halted}, 32'd1);
        check_eq("h_req",    {31'd0, imem_req}, 32'd0);
        check_eq("h_valid",  {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("h_stay_halted", {31'd0, halted}, 32'd1);
            check_eq("h_stay_req",    {31'd0, imem_req}, 32'd0);
        end
        imem_ready = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("hr_halted", {31'd0, halted}, 32'd0);
        check_eq("hr_req",    {31'd0, imem_req}, 32'd1);
        check_eq("hr_addr",   imem_addr, 32'h0);
        check_eq("hr_instr",  instr, 32'h0);

        // Wrap at the top of the address space.
        reset_b = 1'b0;
        check_eq("w_rst_addr", imem_addr_b, 32'hFFFF_FFFC);
        check_eq("w_rst_req",  {31'd0, imem_req_b}, 32'd1);
        imem_ready_b = 1'b1;
        imem_rdata_b = 32'h0000_0001;
        tick();
        imem_ready_b = 1'b0;
        check_eq("w_pc_out",   pc_out_b, 32'hFFFF_FFFC);
        check_eq("w_pc_plus4", pc_plus4_b, 32'h0);
        tick();
        check_eq("w_addr", imem_addr_b, 32'h0);
        check_eq("w_req",  {31'd0, imem_req_b}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
